toggle_pulse_gen: RTL and testbench
===================================

Name: toggle_pulse_gen

Overview:
- Upstream driver for the T flip-flop stage.
- Takes a raw, asynchronous, bouncy push-button level and synchronises and debounces it.
- Emits exactly one single-cycle toggle pulse per clean press; this pulse drives the flip-flop's T input directly.
- Also keeps a running press count and a debounced-level status for the rest of the design.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive identical synchronised samples required to accept a press or release; must be >= 2.
- CNT_W, 3, width of the internal debounce counter; must hold DEBOUNCE_CYCLES-1.
- COUNT_W, 8, width of press_count.

Ports:
- clk  input  1  single system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- btn_in  input  1  raw button level, asynchronous to clk, may bounce.
- en  input  1  pulse enable; when 0, accepted presses produce no t_out and no count.
- t_out  output  1  registered one-cycle toggle pulse, connects to the flip-flop T input.
- btn_stable  output  1  registered debounced button level.
- press_count  output  COUNT_W  number of enabled accepted presses, wraps modulo 2^COUNT_W.

Behaviour:
- Reset (async, active-high): sync flops=0, state=IDLE, debounce cnt=0, t_out=0, btn_stable=0, press_count=0.
- Reset asserted mid-debounce or mid-pulse aborts immediately; no pulse is emitted after release of rst until a full new press is seen.
- Synchroniser: two flops, btn_in -> s1 -> s; the FSM uses s only.
- FSM states: IDLE, DB_PRESS, PRESSED, DB_RELEASE.
- IDLE:
  - s=1 -> DB_PRESS, cnt=1.
  - s=0 -> stay.
- DB_PRESS:
  - s=0 -> IDLE, cnt=0 (bounce rejected).
  - s=1 and cnt=DEBOUNCE_CYCLES-1 -> PRESSED, cnt=0, t_out<=en, press_count+=en.
  - s=1 otherwise -> cnt+1.
- PRESSED:
  - s=0 -> DB_RELEASE, cnt=1.
  - s=1 -> stay.
- DB_RELEASE:
  - s=1 -> PRESSED (bounce rejected, no new pulse).
  - s=0 and cnt=DEBOUNCE_CYCLES-1 -> IDLE, cnt=0.
  - s=0 otherwise -> cnt+1.
- t_out:
  - High for exactly one clock, in the first cycle the state is PRESSED after DB_PRESS.
  - Returning from DB_RELEASE to PRESSED never asserts it.
- btn_stable: 1 exactly when state is PRESSED or DB_RELEASE.
- Latency (btn_in clean high set up before edge 1, DEBOUNCE_CYCLES=4):
  - s high after edge 2; DB_PRESS after edge 3.
  - PRESSED, t_out=1 and btn_stable=1 after edge 6.
  - t_out=0 after edge 7.
  - General case: t_out rises DEBOUNCE_CYCLES+2 edges after the input edge.
- Release latency: btn_stable falls DEBOUNCE_CYCLES+2 edges after a clean btn_in fall.
- press_count wraps from 2^COUNT_W-1 to 0 with no flag.
- en is sampled only on the accepting edge. If en toggles at any other time, that does not change the FSM path.
- A press held indefinitely produces one pulse only.

Test Plan:
1. Reset, then btn_in=1 held clean -> t_out high exactly one cycle, 6 edges after the input edge. btn_stable=1 from that cycle. press_count=1.
2. Glitches on btn_in: high 2 cycles, low 1, high 2, low thereafter -> t_out never asserts; btn_stable stays 0; press_count=0.
3. Accepted press followed by release bounce (low 2 cycles, high 1, low steady) -> single t_out. btn_stable drops only after 4 consecutive low samples; no second pulse.
4. en=0 during a clean press, then en=1 for the next clean press -> first press: btn_stable=1, t_out=0, count stays 0. Second press: one pulse, press_count=1.
5. rst pulsed while in DB_PRESS with cnt=2 -> all outputs 0 immediately (asynchronously). If btn_in is still high, a pulse appears 6 edges after rst deasserts, not earlier.
6. 256 clean presses with COUNT_W=8 -> press_count returns to 0 and t_out pulse count is 256. Chaining t_out into the T flip-flop gives a Q toggle on each pulse, with Q equal to its reset value after an even number of presses.

Source files
------------

// File: rtl/toggle_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module   : toggle_pulse_gen
//  Purpose  : Synchronises and debounces a raw push-button level and emits a
//             single-cycle toggle pulse per clean press, for driving the T
//             input of a downstream T flip-flop.
//  Ports    : clk         - system clock, rising edge
//             rst         - asynchronous active-high reset
//             btn_in      - raw, asynchronous, possibly bouncing button level
//             en          - pulse enable, sampled on the press-accepting edge
//             t_out       - registered one-cycle toggle pulse
//             btn_stable  - registered debounced button level
//             press_count - enabled accepted presses, wraps mod 2^COUNT_W
//  Revision : 1.0 - initial release
// ============================================================================
module toggle_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3,
    parameter int COUNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_in,
    input  logic               en,
    output logic               t_out,
    output logic               btn_stable,
    output logic [COUNT_W-1:0] press_count
);

    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_DB_PRESS   = 2'd1;
    localparam logic [1:0] c_PRESSED    = 2'd2;
    localparam logic [1:0] c_DB_RELEASE = 2'd3;

    // Counter value on which the final confirming sample is seen.
    localparam logic [CNT_W-1:0] c_DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic               r_s1;
    logic               r_s;
    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_t_out;
    logic               r_btn_stable;
    logic [COUNT_W-1:0] r_press_count;

    logic [1:0]         w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_accept;
    logic               w_pulse;
    logic               w_stable_nxt;

    // Two-flop synchroniser; only r_s is visible to the state machine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s  <= 1'b0;
        end else begin
            r_s1 <= btn_in;
            r_s  <= r_s1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (r_s) begin
                    w_state_nxt = c_DB_PRESS;
                    w_cnt_nxt   = c_CNT_ONE;
                end
            end
            c_DB_PRESS: begin
                if (!r_s) begin
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_DB_LAST) begin
                    w_state_nxt = c_PRESSED;
                    w_cnt_nxt   = '0;
                    w_accept    = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
            c_PRESSED: begin
                if (!r_s) begin
                    w_state_nxt = c_DB_RELEASE;
                    w_cnt_nxt   = c_CNT_ONE;
                end
            end
            c_DB_RELEASE: begin
                // A bounce back high returns to PRESSED without re-accepting,
                // so no second pulse can be generated for the same press.
                if (r_s) begin
                    w_state_nxt = c_PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_DB_LAST) begin
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // en only matters on the single accepting edge.
    assign w_pulse      = w_accept & en;
    assign w_stable_nxt = (w_state_nxt == c_PRESSED) || (w_state_nxt == c_DB_RELEASE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_cnt         <= '0;
            r_t_out       <= 1'b0;
            r_btn_stable  <= 1'b0;
            r_press_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_t_out       <= w_pulse;
            r_btn_stable  <= w_stable_nxt;
            r_press_count <= r_press_count + COUNT_W'(w_pulse);
        end
    end

    assign t_out       = r_t_out;
    assign btn_stable  = r_btn_stable;
    assign press_count = r_press_count;

endmodule
`default_nettype wire

// File: tb/tb_toggle_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_toggle_pulse_gen
//  Purpose  : Self-checking bench for toggle_pulse_gen: per-cycle vector table
//             for press/bounce/enable behaviour, plus hand-written sequences
//             for asynchronous reset abort and press-count wrap with a
//             chained T flip-flop.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_toggle_pulse_gen;

    typedef struct {
        logic       btn;
        logic       en;
        logic       exp_t;
        logic       exp_stable;
        logic [7:0] exp_cnt;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       btn_in;
    logic       en;
    logic       t_out;
    logic       btn_stable;
    logic [7:0] press_count;

    int   n_tests;
    int   n_fail;
    int   mon_pulses;
    logic r_q;
    vec_t vecs[$];

    toggle_pulse_gen #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3),
        .COUNT_W        (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .en         (en),
        .t_out      (t_out),
        .btn_stable (btn_stable),
        .press_count(press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream T flip-flop fed by the pulse, plus a pulse-cycle counter.
    always @(posedge clk or posedge rst) begin
        if (rst)        r_q <= 1'b0;
        else if (t_out) r_q <= ~r_q;
    end

    initial mon_pulses = 0;
    always @(negedge clk) begin
        if (t_out) mon_pulses = mon_pulses + 1;
    end

    task automatic check(input string name, input int actual, input int expected);
        n_tests = n_tests + 1;
        if (actual !== expected) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add(input int n, input logic b, input logic e,
                       input logic t, input logic s, input int c);
        vec_t v;
        for (int k = 0; k < n; k++) begin
            v.btn        = b;
            v.en         = e;
            v.exp_t      = t;
            v.exp_stable = s;
            v.exp_cnt    = 8'(c);
            vecs.push_back(v);
        end
    endtask

    // One full clean press-and-release with the given enable and the
    // resulting count before/after the accepting edge.
    task automatic add_press(input logic e, input logic pulse, input int c0, input int c1);
        add(5, 1'b1, e, 1'b0, 1'b0, c0);
        add(1, 1'b1, e, pulse, 1'b1, c1);
        add(2, 1'b1, e, 1'b0, 1'b1, c1);
        add(5, 1'b0, e, 1'b0, 1'b1, c1);
        add(2, 1'b0, e, 1'b0, 1'b0, c1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        btn_in  = 1'b0;
        en      = 1'b1;

        // Clean press: pulse on the 6th edge, released 6 edges after fall.
        add_press(1'b1, 1'b1, 0, 1);
        // Press glitches: high 2, low 1, high 2, low -> nothing accepted.
        add(2, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        add(1, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        add(2, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        add(5, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        // Accepted press, then release bounce low 2 / high 1 / low steady.
        add(5, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        add(1, 1'b1, 1'b1, 1'b1, 1'b1, 2);
        add(2, 1'b1, 1'b1, 1'b0, 1'b1, 2);
        add(2, 1'b0, 1'b1, 1'b0, 1'b1, 2);
        add(1, 1'b1, 1'b1, 1'b0, 1'b1, 2);
        add(5, 1'b0, 1'b1, 1'b0, 1'b1, 2);
        add(2, 1'b0, 1'b1, 1'b0, 0, 2);
        // Disabled press: debounced but no pulse and no count.
        add_press(1'b0, 1'b0, 2, 2);
        // Enabled press after it.
        add_press(1'b1, 1'b1, 2, 3);
        // en high only on the accepting edge still produces the pulse.
        add(5, 1'b1, 1'b0, 1'b0, 1'b0, 3);
        add(1, 1'b1, 1'b1, 1'b1, 1'b1, 4);
        add(2, 1'b1, 1'b0, 1'b0, 1'b1, 4);
        add(5, 1'b0, 1'b0, 1'b0, 1'b1, 4);
        add(2, 1'b0, 1'b1, 1'b0, 1'b0, 4);

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_t_out", int'(t_out), 0);
        check("reset_btn_stable", int'(btn_stable), 0);
        check("reset_press_count", int'(press_count), 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            btn_in = vecs[i].btn;
            en     = vecs[i].en;
            tick();
            if (t_out !== vecs[i].exp_t || btn_stable !== vecs[i].exp_stable ||
                press_count !== vecs[i].exp_cnt) begin
                $display("  at vector %0d", i);
            end
            check("vec_t_out", int'(t_out), int'(vecs[i].exp_t));
            check("vec_btn_stable", int'(btn_stable), int'(vecs[i].exp_stable));
            check("vec_press_count", int'(press_count), int'(vecs[i].exp_cnt));
        end

        // Asynchronous reset while in DB_PRESS with cnt=2 (after 4 edges).
        en     = 1'b1;
        btn_in = 1'b1;
        repeat (4) tick();
        check("pre_rst_count", int'(press_count), 4);
        rst = 1'b1;
        #1;
        check("async_rst_t_out", int'(t_out), 0);
        check("async_rst_btn_stable", int'(btn_stable), 0);
        check("async_rst_press_count", int'(press_count), 0);
        tick();
        rst = 1'b0;
        for (int r = 1; r <= 6; r++) begin
            tick();
            check("post_rst_t_out", int'(t_out), (r == 6) ? 1 : 0);
        end
        check("post_rst_count", int'(press_count), 1);
        check("post_rst_stable", int'(btn_stable), 1);
        btn_in = 1'b0;
        repeat (8) tick();
        check("post_rst_released", int'(btn_stable), 0);

        // 256 clean presses: count wraps, T flip-flop returns to reset value.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        begin
            int p0;
            p0 = mon_pulses;
            for (int i = 0; i < 256; i++) begin
                btn_in = 1'b1;
                repeat (8) tick();
                btn_in = 1'b0;
                repeat (8) tick();
                if (i == 0) check("tff_after_first", int'(r_q), 1);
                if (i == 254) check("count_at_255", int'(press_count), 255);
            end
            check("count_wrapped", int'(press_count), 0);
            check("pulse_cycles_256", mon_pulses - p0, 256);
            check("tff_even_presses", int'(r_q), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
